// File: rtl/picorv32_arb_pkg.sv
// Shared types for the two-port PicoRV32 native memory arbiter.
package picorv32_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/picorv32_arb_watchdog.sv
// Stall watchdog for the arbiter: counts BUSY cycles without ready and raises
// a sticky flag recording the port that was stuck.
module picorv32_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  input  logic err_clear,
  input  logic port,
  output logic timeout_err,
  output logic timeout_port
);

  localparam bit          ENABLE = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(ENABLE ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q;
  logic          stalled;
  logic          fire;

  assign stalled = ENABLE && busy && !ready;
  // Fire on the edge that brings the count up to the limit; the count then
  // saturates so the flag is raised once per transaction.
  assign fire    = stalled && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      timeout_err  <= 1'b0;
      timeout_port <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
      end else if (stalled && (cnt_q != LIMIT)) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (fire) begin
        timeout_err  <= 1'b1;
        timeout_port <= port;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native memory port between two
// requesters; one registered transaction in flight, response routed back.
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned PRIO_RESET     = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        s0_mem_valid,
  input  logic        s0_mem_instr,
  input  logic [31:0] s0_mem_addr,
  input  logic [31:0] s0_mem_wdata,
  input  logic [3:0]  s0_mem_wstrb,
  output logic        s0_mem_ready,
  output logic [31:0] s0_mem_rdata,

  input  logic        s1_mem_valid,
  input  logic        s1_mem_instr,
  input  logic [31:0] s1_mem_addr,
  input  logic [31:0] s1_mem_wdata,
  input  logic [3:0]  s1_mem_wstrb,
  output logic        s1_mem_ready,
  output logic [31:0] s1_mem_rdata,

  output logic        m_mem_valid,
  output logic        m_mem_instr,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic        m_mem_ready,
  input  logic [31:0] m_mem_rdata,

  input  logic        err_clear,
  output logic        timeout_err,
  output logic        timeout_port
);

  arb_state_t state_q, state_d;

  mem_req_t   req [NUM_PORTS];
  mem_req_t   m_req_q;
  logic       m_valid_q;
  logic       grant_q;
  logic       prio_q;
  logic       grant_sel;
  logic       any_valid;
  logic       grant_fire;

  logic [NUM_PORTS-1:0] ready_q;
  logic [31:0]          rdata_q [NUM_PORTS];

  always_comb begin
    req[0] = '{instr: s0_mem_instr, addr: s0_mem_addr, wdata: s0_mem_wdata, wstrb: s0_mem_wstrb};
    req[1] = '{instr: s1_mem_instr, addr: s1_mem_addr, wdata: s1_mem_wdata, wstrb: s1_mem_wstrb};
  end

  assign any_valid  = s0_mem_valid | s1_mem_valid;
  // A lone requester wins outright; the pointer only breaks ties.
  assign grant_sel  = (s0_mem_valid && s1_mem_valid) ? prio_q : s1_mem_valid;
  assign grant_fire = (state_q == IDLE) && any_valid;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid)   state_d = BUSY;
      BUSY:    if (m_mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_req_q    <= '0;
      m_valid_q  <= 1'b0;
      grant_q    <= 1'b0;
      prio_q     <= (PRIO_RESET != 0);
      ready_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      ready_q <= '0;
      if (grant_fire) begin
        m_req_q   <= req[grant_sel];
        m_valid_q <= 1'b1;
        grant_q   <= grant_sel;
        prio_q    <= ~grant_sel;
      end
      // Response data goes straight into the granted port's register, which
      // then holds until that port's next completion.
      if ((state_q == BUSY) && m_mem_ready) begin
        m_valid_q         <= 1'b0;
        ready_q[grant_q]  <= 1'b1;
        rdata_q[grant_q]  <= m_mem_rdata;
      end
    end
  end

  assign m_mem_valid  = m_valid_q;
  assign m_mem_instr  = m_req_q.instr;
  assign m_mem_addr   = m_req_q.addr;
  assign m_mem_wdata  = m_req_q.wdata;
  assign m_mem_wstrb  = m_req_q.wstrb;

  assign s0_mem_ready = ready_q[0];
  assign s1_mem_ready = ready_q[1];
  assign s0_mem_rdata = rdata_q[0];
  assign s1_mem_rdata = rdata_q[1];

  picorv32_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .start       (grant_fire),
    .busy        (state_q == BUSY),
    .ready       (m_mem_ready),
    .err_clear   (err_clear),
    .port        (grant_q),
    .timeout_err (timeout_err),
    .timeout_port(timeout_port)
  );

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench for picorv32_mem_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_picorv32_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_mem_valid, s0_mem_instr, s0_mem_ready;
  logic [31:0] s0_mem_addr, s0_mem_wdata, s0_mem_rdata;
  logic [3:0]  s0_mem_wstrb;
  logic        s1_mem_valid, s1_mem_instr, s1_mem_ready;
  logic [31:0] s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
  logic [3:0]  s1_mem_wstrb;
  logic        m_mem_valid, m_mem_instr, m_mem_ready;
  logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic [3:0]  m_mem_wstrb;
  logic        err_clear, timeout_err, timeout_port;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .PRIO_RESET    (0)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_mem_valid(s0_mem_valid), .s0_mem_instr(s0_mem_instr), .s0_mem_addr(s0_mem_addr),
    .s0_mem_wdata(s0_mem_wdata), .s0_mem_wstrb(s0_mem_wstrb),
    .s0_mem_ready(s0_mem_ready), .s0_mem_rdata(s0_mem_rdata),
    .s1_mem_valid(s1_mem_valid), .s1_mem_instr(s1_mem_instr), .s1_mem_addr(s1_mem_addr),
    .s1_mem_wdata(s1_mem_wdata), .s1_mem_wstrb(s1_mem_wstrb),
    .s1_mem_ready(s1_mem_ready), .s1_mem_rdata(s1_mem_rdata),
    .m_mem_valid(m_mem_valid), .m_mem_instr(m_mem_instr), .m_mem_addr(m_mem_addr),
    .m_mem_wdata(m_mem_wdata), .m_mem_wstrb(m_mem_wstrb),
    .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
    .err_clear(err_clear), .timeout_err(timeout_err), .timeout_port(timeout_port)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Requester intent, driven onto the DUT by drive().
  logic        rv [2];
  logic        ri [2];
  logic [31:0] ra [2];
  logic [31:0] rw [2];
  logic [3:0]  rs [2];

  // Reference model state.
  int          m_ptr;
  logic        m_flag;
  logic        m_port;
  logic [31:0] m_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_mem_valid = rv[0]; s0_mem_instr = ri[0]; s0_mem_addr = ra[0];
    s0_mem_wdata = rw[0]; s0_mem_wstrb = rs[0];
    s1_mem_valid = rv[1]; s1_mem_instr = ri[1]; s1_mem_addr = ra[1];
    s1_mem_wdata = rw[1]; s1_mem_wstrb = rs[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int p);
    rv[p] = 1'($urandom_range(0, 1));
    ri[p] = 1'($urandom_range(0, 1));
    ra[p] = $urandom;
    rw[p] = $urandom;
    rs[p] = 4'($urandom_range(0, 15));
  endtask

  task automatic set_req(input int p, input logic v, input logic i, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
    rv[p] = v; ri[p] = i; ra[p] = a; rw[p] = w; rs[p] = s;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_flag = 1'b0; m_port = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, m_mem_valid, 0);
    chk({tag, "_ready"}, {s1_mem_ready, s0_mem_ready}, 0);
    chk({tag, "_rdata0"}, s0_mem_rdata, m_rd[0]);
    chk({tag, "_rdata1"}, s1_mem_rdata, m_rd[1]);
    chk({tag, "_terr"}, timeout_err, m_flag);
    chk({tag, "_tport"}, timeout_port, m_port);
  endtask

  task automatic tick_idle();
    tick();
    if (err_clear) m_flag = 1'b0;
    err_clear = 1'b0;
    check_quiet("idle");
  endtask

  // One full transaction starting in IDLE with at least one valid driven.
  // next_mode after completion: 0 granted port drops, 1 keeps, 2 random.
  task automatic run_txn(input int waits, input logic [31:0] rd, input int clr_at,
                         input int next_mode, input bit toggle, output int got);
    int g;
    logic ei; logic [31:0] ea, ew; logic [3:0] es;
    g  = (rv[0] && rv[1]) ? m_ptr : (rv[1] ? 1 : 0);
    ei = ri[g]; ea = ra[g]; ew = rw[g]; es = rs[g];
    m_mem_ready = 1'b0;
    tick();
    m_ptr = 1 - g;
    chk("grant_valid", m_mem_valid, 1);
    chk("grant_instr", m_mem_instr, ei);
    chk("grant_addr",  m_mem_addr, ea);
    chk("grant_wdata", m_mem_wdata, ew);
    chk("grant_wstrb", m_mem_wstrb, es);
    chk("grant_noready", {s1_mem_ready, s0_mem_ready}, 0);
    for (int i = 0; i < waits; i++) begin
      m_mem_rdata = $urandom;
      if (toggle) begin rand_req(1 - g); drive(); end
      err_clear = ((i + 1) == clr_at);
      tick();
      if ((i + 1) == TO) begin m_flag = 1'b1; m_port = (g == 1); end
      else if (err_clear) m_flag = 1'b0;
      err_clear = 1'b0;
      chk("hold_valid", m_mem_valid, 1);
      chk("hold_instr", m_mem_instr, ei);
      chk("hold_addr",  m_mem_addr, ea);
      chk("hold_wdata", m_mem_wdata, ew);
      chk("hold_wstrb", m_mem_wstrb, es);
      chk("hold_noready", {s1_mem_ready, s0_mem_ready}, 0);
      chk("hold_terr", timeout_err, m_flag);
      chk("hold_tport", timeout_port, m_port);
    end
    m_mem_ready = 1'b1; m_mem_rdata = rd;
    tick();
    m_mem_ready = 1'b0; m_mem_rdata = $urandom;
    m_rd[g] = rd;
    chk("resp_valid_low", m_mem_valid, 0);
    chk("resp_ready", {s1_mem_ready, s0_mem_ready}, (g == 1) ? 2 : 1);
    chk("resp_rdata0", s0_mem_rdata, m_rd[0]);
    chk("resp_rdata1", s1_mem_rdata, m_rd[1]);
    chk("resp_terr", timeout_err, m_flag);
    got = s1_mem_ready ? 1 : 0;
    if (next_mode == 0) rv[g] = 1'b0;
    else if (next_mode == 2) rand_req(g);
    drive();
    tick();
    check_quiet("post");
  endtask

  initial begin
    int got;
    int order [4];
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
    reset = 1'b1; err_clear = 1'b0; m_mem_ready = 1'b0; m_mem_rdata = '0;
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, '0, '0, '0);
    drive();
    model_reset();
    tick(); tick();
    check_quiet("reset");
    chk("reset_addr", m_mem_addr, 0);
    chk("reset_wdata", m_mem_wdata, 0);
    chk("reset_wstrb", m_mem_wstrb, 0);
    chk("reset_instr", m_mem_instr, 0);
    reset = 1'b0;
    tick_idle();

    // Single read on s0, two wait cycles.
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0, 4'h0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    drive();
    run_txn(2, 32'hCAFE_F00D, -1, 0, 1'b0, got);
    chk("single_read_port", got, 0);
    tick_idle();

    // Write pass-through on s1.
    set_req(1, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 4'b0110);
    drive();
    run_txn(1, 32'h5A5A_0001, -1, 0, 1'b0, got);
    chk("write_port", got, 1);
    tick_idle();

    // Contention after reset: strict alternation starting at port 0.
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    set_req(0, 1'b1, 1'b1, 32'h0000_00A0, 32'h1, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h2, 4'hF);
    drive();
    for (int k = 0; k < 4; k++) begin
      run_txn(k % 2, $urandom, -1, 1, 1'b0, got);
      chk("contention_order", got, order[k]);
    end
    rv[0] = 1'b0; rv[1] = 1'b0; drive();
    tick_idle();

    // Stability: non-granted port toggles throughout a 5-cycle stall.
    set_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 4'hF);
    rv[1] = 1'b0; drive();
    run_txn(5, 32'h0BAD_F00D, -1, 0, 1'b1, got);
    chk("stability_port", got, 0);
    rv[0] = 1'b0; rv[1] = 1'b0; drive();
    tick_idle();

    // Timeout on s1, late completion, then clear.
    set_req(1, 1'b1, 1'b0, 32'h0000_0800, '0, 4'h0);
    drive();
    run_txn(10, 32'h7777_0000, -1, 0, 1'b0, got);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_port", timeout_port, 1);
    err_clear = 1'b1;
    tick_idle();
    chk("cleared_flag", timeout_err, 0);

    // Timeout on s0, then set-vs-clear in the same cycle, then clear mid-BUSY.
    set_req(0, 1'b1, 1'b0, 32'h0000_0900, '0, 4'h0);
    drive();
    run_txn(8, 32'h0000_0009, -1, 1, 1'b0, got);
    chk("timeout_port0", timeout_port, 0);
    run_txn(9, 32'h0000_000A, 8, 1, 1'b0, got);
    chk("set_wins", timeout_err, 1);
    run_txn(5, 32'h0000_000B, 3, 0, 1'b0, got);
    chk("clear_in_busy", timeout_err, 0);
    tick_idle();

    // Reset in BUSY: valid drops without ready, pointer back to port 0.
    set_req(0, 1'b1, 1'b0, 32'h0000_0C00, '0, 4'h0);
    drive();
    tick();
    chk("pre_reset_valid", m_mem_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; model_reset();
    check_quiet("mid_reset");
    chk("mid_reset_addr", m_mem_addr, 0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0D00, '0, 4'h0);
    drive();
    run_txn(0, 32'h0000_1111, -1, 0, 1'b0, got);
    chk("post_reset_prio", got, 0);
    run_txn(1, 32'h0000_2222, -1, 0, 1'b0, got);
    chk("post_reset_s1", got, 1);

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      if (rv[0] || rv[1]) begin
        run_txn($urandom_range(0, 4), $urandom, -1, 2, 1'b1, got);
      end else begin
        tick_idle();
        rand_req(0); rand_req(1); drive();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
